// File: rtl/controle_pipeline.sv
// Pipelined control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// load-use stall, branch flush and retired counter. Optional JALR decode: CONTROLE_JALR_EN.
module controle_pipeline #(
  parameter int ALUCTRL_W = 4,
  parameter int REG_W     = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [31:0]          iInst,
  input  logic                 iValid,
  input  logic                 iBranchTaken,
  output logic                 oStall,
  output logic [ALUCTRL_W-1:0] oEx_ALUControl,
  output logic                 oEx_ALUSrc,
  output logic                 oEx_Branch,
  output logic [1:0]           oEx_OrigPC,
  output logic [REG_W-1:0]     oEx_Rd,
  output logic                 oMem_MemRead,
  output logic                 oMem_MemWrite,
  output logic                 oWb_RegWrite,
  output logic [1:0]           oWb_MemtoReg,
  output logic [REG_W-1:0]     oWb_Rd,
  output logic [CNT_W-1:0]     oRetired
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR = ALUCTRL_W'(5);

  typedef struct packed {
    logic                 valid;
    logic [ALUCTRL_W-1:0] aluctrl;
    logic                 alusrc;
    logic                 branch;
    logic [1:0]           origpc;
    logic                 memread;
    logic                 memwrite;
    logic                 regwrite;
    logic [1:0]           memtoreg;
    logic [REG_W-1:0]     rd;
  } ctrl_t;

  // Fields that survive past EX
  typedef struct packed {
    logic             valid;
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic [1:0]       memtoreg;
    logic [REG_W-1:0] rd;
  } late_t;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [REG_W-1:0] rd_f;
  logic [REG_W-1:0] rs1_f;
  logic [REG_W-1:0] rs2_f;

  assign opcode = iInst[6:0];
  assign funct3 = iInst[14:12];
  assign funct7 = iInst[31:25];
  assign rd_f   = REG_W'(iInst[11:7]);
  assign rs1_f  = REG_W'(iInst[19:15]);
  assign rs2_f  = REG_W'(iInst[24:20]);

  ctrl_t dec;
  logic  uses_rs1;
  logic  uses_rs2;

  ctrl_t idex_q;
  late_t exmem_q;
  late_t memwb_q;
  logic [CNT_W-1:0] retired_q;

  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (iValid) begin
      case (opcode)
        OP_R: begin
          dec.valid    = 1'b1;
          dec.regwrite = 1'b1;
          dec.rd       = rd_f;
          uses_rs1     = 1'b1;
          uses_rs2     = 1'b1;
          case (funct3)
            3'b000:  dec.aluctrl = (funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
            3'b111:  dec.aluctrl = ALU_AND;
            3'b110:  dec.aluctrl = ALU_OR;
            3'b010:  dec.aluctrl = ALU_SLT;
            3'b100:  dec.aluctrl = ALU_XOR;
            default: dec.aluctrl = ALU_ADD;
          endcase
        end
        OP_I: begin
          dec.valid    = 1'b1;
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
          dec.rd       = rd_f;
          uses_rs1     = 1'b1;
          case (funct3)
            3'b111:  dec.aluctrl = ALU_AND;
            3'b110:  dec.aluctrl = ALU_OR;
            3'b100:  dec.aluctrl = ALU_XOR;
            3'b010:  dec.aluctrl = ALU_SLT;
            default: dec.aluctrl = ALU_ADD;
          endcase
        end
        OP_LOAD: begin
          dec.valid    = 1'b1;
          dec.alusrc   = 1'b1;
          dec.memread  = 1'b1;
          dec.regwrite = 1'b1;
          dec.memtoreg = 2'b01;
          dec.rd       = rd_f;
          uses_rs1     = 1'b1;
        end
        OP_STORE: begin
          dec.valid    = 1'b1;
          dec.alusrc   = 1'b1;
          dec.memwrite = 1'b1;
          uses_rs1     = 1'b1;
          uses_rs2     = 1'b1;
        end
        OP_B: begin
          dec.valid   = 1'b1;
          dec.branch  = 1'b1;
          dec.aluctrl = ALU_SUB;
          dec.origpc  = 2'b01;
          uses_rs1    = 1'b1;
          uses_rs2    = 1'b1;
        end
        OP_JAL: begin
          dec.valid    = 1'b1;
          dec.regwrite = 1'b1;
          dec.origpc   = 2'b10;
          dec.memtoreg = 2'b10;
          dec.rd       = rd_f;
        end
`ifdef CONTROLE_JALR_EN
        OP_JALR: begin
          dec.valid    = 1'b1;
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
          dec.origpc   = 2'b11;
          dec.memtoreg = 2'b10;
          dec.rd       = rd_f;
          uses_rs1     = 1'b1;
        end
`else
        OP_JALR: ;
`endif
        default: ;
      endcase
    end
  end

  logic hazard;
  assign hazard = idex_q.valid && idex_q.memread && (idex_q.rd != '0) &&
                  ((uses_rs1 && (idex_q.rd == rs1_f)) || (uses_rs2 && (idex_q.rd == rs2_f)));

  // A redirect kills the ID instruction anyway, so it overrides the stall
  assign oStall = hazard && !iBranchTaken;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      retired_q <= '0;
    end else begin
      idex_q           <= (oStall || iBranchTaken) ? '0 : dec;
      exmem_q.valid    <= idex_q.valid;
      exmem_q.memread  <= idex_q.memread;
      exmem_q.memwrite <= idex_q.memwrite;
      exmem_q.regwrite <= idex_q.regwrite;
      exmem_q.memtoreg <= idex_q.memtoreg;
      exmem_q.rd       <= idex_q.rd;
      memwb_q          <= exmem_q;
      if (memwb_q.valid) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign oEx_ALUControl = idex_q.aluctrl;
  assign oEx_ALUSrc     = idex_q.alusrc;
  assign oEx_Branch     = idex_q.branch;
  assign oEx_OrigPC     = idex_q.origpc;
  assign oEx_Rd         = idex_q.rd;
  assign oMem_MemRead   = exmem_q.memread;
  assign oMem_MemWrite  = exmem_q.memwrite;
  assign oWb_RegWrite   = memwb_q.regwrite;
  assign oWb_MemtoReg   = memwb_q.memtoreg;
  assign oWb_Rd         = memwb_q.rd;
  assign oRetired       = retired_q;

endmodule

// File: tb/tb_controle_pipeline.sv
// Scoreboard bench for controle_pipeline: stimulus queues hand-computed expectations with
// a due cycle; a negedge monitor pops and compares them.
module tb_controle_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        valid;
  logic        br;

  logic        stall, alusrc, branch, memrd, memwr, regwr;
  logic [3:0]  aluctl;
  logic [1:0]  origpc, memtoreg;
  logic [4:0]  exrd, wbrd;
  logic [31:0] ret;

  logic        stall4, alusrc4, branch4, memrd4, memwr4, regwr4;
  logic [3:0]  aluctl4;
  logic [1:0]  origpc4, memtoreg4;
  logic [4:0]  exrd4, wbrd4;
  logic [3:0]  ret4;

  always #5 clk = ~clk;

  controle_pipeline u_dut (
    .iCLK(clk), .iRST(rst), .iInst(inst), .iValid(valid), .iBranchTaken(br),
    .oStall(stall), .oEx_ALUControl(aluctl), .oEx_ALUSrc(alusrc), .oEx_Branch(branch),
    .oEx_OrigPC(origpc), .oEx_Rd(exrd), .oMem_MemRead(memrd), .oMem_MemWrite(memwr),
    .oWb_RegWrite(regwr), .oWb_MemtoReg(memtoreg), .oWb_Rd(wbrd), .oRetired(ret)
  );

  controle_pipeline #(.CNT_W(4)) u_dut4 (
    .iCLK(clk), .iRST(rst), .iInst(inst), .iValid(valid), .iBranchTaken(br),
    .oStall(stall4), .oEx_ALUControl(aluctl4), .oEx_ALUSrc(alusrc4), .oEx_Branch(branch4),
    .oEx_OrigPC(origpc4), .oEx_Rd(exrd4), .oMem_MemRead(memrd4), .oMem_MemWrite(memwr4),
    .oWb_RegWrite(regwr4), .oWb_MemtoReg(memtoreg4), .oWb_Rd(wbrd4), .oRetired(ret4)
  );

  localparam int K_STALL = 0, K_EXALU = 1, K_EXSRC = 2, K_EXBR = 3, K_EXPC = 4, K_EXRD = 5;
  localparam int K_MEMRD = 6, K_MEMWR = 7, K_WBRW = 8, K_WBMR = 9, K_WBRD = 10, K_RET = 11;
  localparam int K_RET4 = 12, K_ALL0 = 13;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_STALL: return 32'(stall);
      K_EXALU: return 32'(aluctl);
      K_EXSRC: return 32'(alusrc);
      K_EXBR:  return 32'(branch);
      K_EXPC:  return 32'(origpc);
      K_EXRD:  return 32'(exrd);
      K_MEMRD: return 32'(memrd);
      K_MEMWR: return 32'(memwr);
      K_WBRW:  return 32'(regwr);
      K_WBMR:  return 32'(memtoreg);
      K_WBRD:  return 32'(wbrd);
      K_RET:   return ret;
      K_RET4:  return 32'(ret4);
      default: return 32'({stall, aluctl, alusrc, branch, origpc, exrd, memrd, memwr,
                           regwr, memtoreg, wbrd} != '0) | ret | 32'(ret4);
    endcase
  endfunction

  // Monitor: compare every entry due this cycle
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        logic [31:0] a;
        a = actual(q[i].kind);
        tests++;
        if (a !== q[i].exp) begin
          fails++;
          $display("FAIL %s (cycle %0d): got %0h, expected %0h", q[i].name, cyc, a, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  task automatic chk(input int kind, input int ofs, input logic [31:0] exp, input string name);
    ent_t e;
    e.due = cyc + ofs;
    e.kind = kind;
    e.exp = exp;
    e.name = name;
    q.push_back(e);
  endtask

  // Present one ID-stage input for one cycle
  task automatic drive(input logic [31:0] i, input logic v, input logic b, input logic r);
    inst = i;
    valid = v;
    br = b;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD3  = 32'h002081B3;
  localparam logic [31:0] SUB4  = 32'h40208233;
  localparam logic [31:0] LW5   = 32'h0000A283;
  localparam logic [31:0] ADD6  = 32'h00128333;
  localparam logic [31:0] BEQ   = 32'h00208063;
  localparam logic [31:0] SW    = 32'h0020A023;
  localparam logic [31:0] LW0   = 32'h0000A003;
  localparam logic [31:0] ADDX0 = 32'h00100333;
  localparam logic [31:0] SW5   = 32'h0050A023;
  localparam logic [31:0] JALR  = 32'h000100E7;

  initial begin
    rst = 1'b1; inst = '0; valid = 1'b0; br = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_stall: got %0h, expected 0", stall);
    end
    tests++;
    if ({ret, ret4} !== '0) begin
      fails++;
      $display("FAIL reset_retired: got %0h/%0h, expected 0", ret, ret4);
    end
    tests++;
    if (exrd !== 5'd0) begin
      fails++;
      $display("FAIL reset_exrd: got %0h, expected 0", exrd);
    end
    tests++;
    if (regwr !== 1'b0) begin
      fails++;
      $display("FAIL reset_wbregwrite: got %0h, expected 0", regwr);
    end

    chk(K_ALL0, 0, 0, "reset_all0");
    chk(K_EXALU, 1, 0, "add_alu");
    chk(K_EXRD, 1, 3, "add_exrd");
    chk(K_WBRW, 3, 1, "add_wbrw");
    chk(K_WBRD, 3, 3, "add_wbrd");
    chk(K_RET, 4, 1, "add_retired");
    drive(ADD3, 1, 0, 0);

    chk(K_EXALU, 1, 1, "sub_alu");
    chk(K_EXSRC, 1, 0, "sub_alusrc");
    chk(K_EXRD, 1, 4, "sub_exrd");
    chk(K_RET, 4, 2, "sub_retired");
    drive(SUB4, 1, 0, 0);

    chk(K_EXRD, 1, 5, "lw_exrd");
    chk(K_MEMRD, 2, 1, "lw_memrd");
    chk(K_WBMR, 3, 1, "lw_wbmemtoreg");
    chk(K_WBRD, 3, 5, "lw_wbrd");
    drive(LW5, 1, 0, 0);
    chk(K_STALL, 0, 1, "loaduse_stall");
    chk(K_EXRD, 1, 0, "stall_bubble_rd");
    chk(K_EXBR, 1, 0, "stall_bubble_br");
    drive(ADD6, 1, 0, 0);
    chk(K_STALL, 0, 0, "stall_one_cycle");
    chk(K_EXRD, 1, 6, "add6_exrd");
    chk(K_EXALU, 1, 0, "add6_alu");
    drive(ADD6, 1, 0, 0);

    // Flush wins over a simultaneous load-use match
    drive(LW5, 1, 0, 0);
    chk(K_STALL, 0, 0, "flush_nostall");
    chk(K_EXRD, 1, 0, "flush_exrd");
    chk(K_EXBR, 1, 0, "flush_exbr");
    drive(ADD6, 1, 1, 0);
    chk(K_RET, 4, 5, "flush_not_retired");
    drive(32'h0, 0, 0, 0);

    chk(K_EXBR, 1, 1, "beq_branch");
    chk(K_EXPC, 1, 1, "beq_origpc");
    chk(K_EXALU, 1, 1, "beq_alu");
    chk(K_EXRD, 1, 0, "beq_rd0");
    drive(BEQ, 1, 0, 0);
    chk(K_MEMWR, 2, 1, "sw_memwrite");
    chk(K_EXRD, 1, 0, "sw_rd0");
    drive(SW, 1, 0, 0);
    drive(LW0, 1, 0, 0);
    chk(K_STALL, 0, 0, "rd0_nostall");
    drive(ADDX0, 1, 0, 0);
    drive(LW5, 1, 0, 0);
    chk(K_STALL, 0, 1, "store_rs2_stall");
    drive(SW5, 1, 0, 0);
    drive(SW5, 1, 0, 0);

`ifdef CONTROLE_JALR_EN
    chk(K_EXPC, 1, 3, "jalr_origpc");
    chk(K_EXSRC, 1, 1, "jalr_alusrc");
    chk(K_EXRD, 1, 1, "jalr_rd");
    chk(K_WBMR, 3, 2, "jalr_memtoreg");
    chk(K_RET, 4, 12, "jalr_retired");
`else
    chk(K_EXPC, 1, 0, "jalr_off_origpc");
    chk(K_EXRD, 1, 0, "jalr_off_rd");
    chk(K_WBRW, 3, 0, "jalr_off_regwrite");
    chk(K_RET, 4, 11, "jalr_off_retired");
`endif
    drive(JALR, 1, 0, 0);
    repeat (4) drive(32'h0, 0, 0, 0);

    // Reset with three instructions in flight and a pending stall/flush
    drive(ADD3, 1, 0, 0);
    drive(SUB4, 1, 0, 0);
    drive(LW5, 1, 0, 0);
    chk(K_ALL0, 1, 0, "midstream_reset_all0");
    drive(ADD6, 1, 1, 1);

    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        chk(K_RET, 4, 17, "stream17_retired");
        chk(K_RET4, 4, 1, "cnt4_wrap");
      end
      drive(ADD3, 1, 0, 0);
    end
    repeat (6) drive(32'h0, 0, 0, 0);

    foreach (q[i]) begin
      tests++;
      fails++;
      $display("FAIL %s: never compared, expected %0h by cycle %0d", q[i].name, q[i].exp, q[i].due);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controle_pipeline.md
# controle_pipeline

Parametrised pipelined successor to the single-cycle control decoder. Decodes the RV32 subset in the ID stage and carries control fields through ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards (stall), applies branch/jump flushes, and counts retired instructions. Sits between the IF/ID register and the datapath stage registers of the pipelined core.

## Interface
- ALUCTRL_W, 4, ALU control width; ALU codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, XOR=5
- REG_W, 5, register-index width
- CNT_W, 32, retired-instruction counter width
- Clock port is iCLK; reset port is iRST, synchronous and active-high.
- iCLK  in  1  clock
- iRST  in  1  synchronous active-high reset
- iInst  in  32  instruction in ID (from IF/ID)
- iValid  in  1  iInst is a real instruction; 0 decodes as bubble
- iBranchTaken  in  1  EX-stage branch/jump redirect
- oStall  out  1  hold PC and IF/ID; combinational
- oEx_ALUControl  out  ALUCTRL_W  ID/EX field
- oEx_ALUSrc, oEx_Branch  out  1 each  ID/EX fields
- oEx_OrigPC  out  2  00 PC+4, 01 branch, 10 JAL, 11 JALR
- oEx_Rd  out  REG_W  ID/EX destination
- oMem_MemRead, oMem_MemWrite  out  1 each  EX/MEM fields
- oWb_RegWrite  out  1  MEM/WB field
- oWb_MemtoReg  out  2  00 ALU, 01 memory, 10 PC+4
- oWb_Rd  out  REG_W  MEM/WB destination
- oRetired  out  CNT_W  valid instructions that reached WB

## Operation
- Decode opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, B 1100011, JAL 1101111. Field values are unchanged from the single-cycle decoder.
- R-type: funct3 000 gives ADD, or SUB if funct7=0100000. 111 AND, 110 OR, 010 SLT, 100 XOR, others ADD.
- I-type: 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT, others ADD.
- An unknown opcode, or iValid=0, decodes as a bubble: all enables 0, ALU ADD, OrigPC 00, Rd 0, valid bit 0.
- Rd comes from iInst[11:7] for R, I, LOAD and JAL. It is 0 for STORE and B.
- Each stage register holds a valid bit. Only MemRead, MemWrite, RegWrite, MemtoReg, Rd and valid propagate past EX.
- Load-use stall: oStall=1 when all of the following hold:
  - ID/EX valid, MemRead=1 and Rd≠0;
  - and Rd equals rs1 (iInst[19:15]) for R, I, LOAD, STORE or B, or equals rs2 (iInst[24:20]) for R, STORE or B.
- During a stall, ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
- iBranchTaken=1 forces oStall=0 and loads a bubble into ID/EX, killing the ID instruction. EX/MEM still takes the branch/jump itself.
- oRetired increments by 1 on each edge where MEM/WB valid=1. It wraps modulo 2^CNT_W.

## Timing
- Latency from iInst to the registered fields:
  - EX fields valid 1 edge after iInst is presented;
  - MEM fields after 2 edges;
  - WB fields after 3 edges;
  - oRetired reflects the instruction 4 edges after presentation.
- oStall is purely combinational on iInst, iValid, iBranchTaken and ID/EX state.
- Reset, at an iRST edge (overrides all inputs, including mid-stall or mid-flush):
  - all stage registers become bubbles;
  - all registered outputs are 0, oRetired=0, oStall=0.
- iBranchTaken and a load-use match in the same cycle: the flush wins, oStall=0, and ID/EX gets a bubble.
- A stall lasts exactly 1 cycle per load, because the load leaves ID/EX on the next edge.
- Rd=0 never causes a stall.

## Configuration
- CONTROLE_JALR_EN is defined: opcode 1100111 decodes as JALR with these fields:
  - ALUSrc=1, ALU ADD, OrigPC=11, MemtoReg=10, RegWrite=1, Rd=iInst[11:7];
  - rs1 takes part in the hazard check.
- CONTROLE_JALR_EN is undefined: opcode 1100111 decodes as a bubble, and OrigPC=11 is never produced.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) → after 1 edge: oEx_ALUControl=0, oEx_Rd=3. After 3 edges: oWb_RegWrite=1, oWb_Rd=3. After 4 edges: oRetired=1.
- sub x4,x1,x2 (0x40208233) → oEx_ALUControl=1, oEx_ALUSrc=0.
- lw x5,0(x1) (0x0000A283), then add x6,x5,x1 (0x00128333) held in ID →
  - oStall=1 for exactly 1 cycle, and ID/EX is a bubble;
  - the add then reaches EX with Rd=6;
  - oWb_MemtoReg=01 for the lw.
- iBranchTaken=1 during the same lw-then-add hazard → oStall=0, and ID/EX is a bubble (oEx_Rd=0, oEx_Branch=0). oRetired does not count the killed instruction.
- jalr x1,0(x2) (0x000100E7):
  - CONTROLE_JALR_EN defined → oEx_OrigPC=11, oWb_MemtoReg=10;
  - undefined → all fields 0 and oRetired unchanged.
- Assert iRST mid-stream with 3 instructions in flight → after the edge, all outputs are 0. After CNT_W=4, stream 17 valid instructions → oRetired wraps to 1.
